// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared FSM encoding, default sizes and clog2 helper for spi_req_arbiter
// Contents:
//   arb_state_t      arbiter FSM state encoding
//   DEF_*            default parameter values for the arbiter
//   clog2()          ceiling log2, usable in constant expressions
package spi_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WAIT,
      ST_RESP,
      ST_HOLD
   } arb_state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_DW          = 8;
   localparam int DEF_TIMEOUT_CYC = 64;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Ports:
//   req     in   NUM_REQ  request vector
//   ptr     in   IW       index with highest priority this round
//   onehot  out  NUM_REQ  one-hot winner, 0 when no request
//   idx     out  IW       winner index, 0 when no request
//   any     out  1        at least one request present
module rr_pick
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IW      = clog2(DEF_NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IW-1:0]      idx,
   output logic               any
);

   // One spare bit so ptr+k never overflows before the wrap subtraction.
   logic [IW:0] pos;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      pos    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(NUM_REQ)) begin
            pos = pos - (IW+1)'(NUM_REQ);
         end
         if (!any && req[pos[IW-1:0]]) begin
            any                 = 1'b1;
            onehot[pos[IW-1:0]] = 1'b1;
            idx                 = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin arbiter sharing one SPI master between NUM_REQ requesters
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   req          per-requester level request
//   req_lock     keep grant/cs_n after the current transfer (burst)
//   tx_data      flat NUM_REQ*DW, slice i is requester i's byte
//   ack          one-cycle completion pulse for the owning requester
//   err          pulses with ack when the transfer was aborted by the watchdog
//   rx_data      received byte, meaningful in the ack cycle
//   grant        one-hot current owner, 0 when idle
//   cs_n         active-low slave selects, low exactly where grant is set
//   m_start      one-cycle start to the SPI master
//   m_tx_data    byte for the master, held for the whole transfer
//   m_abort      one-cycle abort to the master on watchdog expiry
//   m_done       master completion pulse
//   m_rx_data    master received byte, valid with m_done
module spi_req_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int DW          = DEF_DW,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_lock,
   input  logic [NUM_REQ*DW-1:0] tx_data,
   output logic [NUM_REQ-1:0]    ack,
   output logic                  err,
   output logic [DW-1:0]         rx_data,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    cs_n,
   output logic                  m_start,
   output logic [DW-1:0]         m_tx_data,
   output logic                  m_abort,
   input  logic                  m_done,
   input  logic [DW-1:0]         m_rx_data
);

   localparam int IW = clog2(NUM_REQ);
   localparam int TW = clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

   arb_state_t           state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IW-1:0]        gidx_q, gidx_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [DW-1:0]        tx_q, tx_d;
   logic [DW-1:0]        rx_q, rx_d;
   logic                 err_q, err_d;

   logic [NUM_REQ-1:0]   pick_onehot;
   logic [IW-1:0]        pick_idx;
   logic                 pick_any;
   logic [DW-1:0]        pick_byte;
   logic [DW-1:0]        own_byte;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_pick (
      .req    (req),
      .ptr    (rr_ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Byte of the arbitration winner (IDLE) and of the current owner (HOLD).
   always_comb begin
      pick_byte = '0;
      own_byte  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IW'(i)) pick_byte = tx_data[i*DW +: DW];
         if (gidx_q == IW'(i))   own_byte  = tx_data[i*DW +: DW];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= '0;
         timer_q  <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gidx_q   <= gidx_d;
         rr_ptr_q <= rr_ptr_d;
         timer_q  <= timer_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      rr_ptr_d = rr_ptr_q;
      timer_d  = timer_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      err_d    = err_q;
      m_start  = 1'b0;
      m_abort  = 1'b0;
      ack      = '0;
      err      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick_onehot;
               gidx_d  = pick_idx;
               tx_d    = pick_byte;
               state_d = ST_SETUP;
            end
         end

         // One cycle of chip-select setup before the master is started.
         ST_SETUP: begin
            m_start = 1'b1;
            timer_d = '0;
            err_d   = 1'b0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (timer_q != TMAX) begin
               timer_d = timer_q + TW'(1);
            end
            // A completion arriving on the last allowed cycle still counts as success.
            if (m_done) begin
               rx_d    = m_rx_data;
               state_d = ST_RESP;
            end else if (timer_q == TMAX) begin
               m_abort = 1'b1;
               rx_d    = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            ack      = grant_q;
            err      = err_q;
            rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
            if (req_lock[gidx_q]) begin
               state_d = ST_HOLD;
            end else begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end

         // Burst owner keeps the bus; nobody else is arbitrated until it lets go.
         ST_HOLD: begin
            if (req[gidx_q]) begin
               tx_d    = own_byte;
               state_d = ST_SETUP;
            end else if (!req_lock[gidx_q]) begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign grant     = grant_q;
   assign cs_n      = ~grant_q;
   assign m_tx_data = tx_q;
   assign rx_data   = rx_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - directed self-checking bench for spi_req_arbiter
module tb_spi_req_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  req_lock;
   logic [31:0] tx_data;
   logic [3:0]  ack;
   logic        err;
   logic [7:0]  rx_data;
   logic [3:0]  grant;
   logic [3:0]  cs_n;
   logic        m_start;
   logic [7:0]  m_tx_data;
   logic        m_abort;
   logic        m_done;
   logic [7:0]  m_rx_data;

   int errors   = 0;
   int checks   = 0;
   int inv_viol = 0;
   int cs2_gap  = 0;
   bit watch_cs2 = 1'b0;

   spi_req_arbiter #(
      .NUM_REQ     (4),
      .DW          (8),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_lock  (req_lock),
      .tx_data   (tx_data),
      .ack       (ack),
      .err       (err),
      .rx_data   (rx_data),
      .grant     (grant),
      .cs_n      (cs_n),
      .m_start   (m_start),
      .m_tx_data (m_tx_data),
      .m_abort   (m_abort),
      .m_done    (m_done),
      .m_rx_data (m_rx_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if ($countones(~cs_n) > 1 || $countones(grant) > 1 || cs_n != ~grant) inv_viol++;
      if (watch_cs2 && cs_n[2]) cs2_gap++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (m_start) begin
            ok = 1'b1;
            break;
         end
      end
      check("m_start_seen", 32'(ok), 32'd1);
   endtask

   task automatic run_xfer(input int dly, input logic [7:0] rxb,
                           output logic [3:0] g, output logic [7:0] tx,
                           output logic [3:0] cs_mid, output logic [3:0] ak,
                           output logic [7:0] rx, output logic er);
      bit ok;
      wait_start(ok);
      g  = grant;
      tx = m_tx_data;
      repeat (dly) tick();
      cs_mid    = cs_n;
      m_done    = 1'b1;
      m_rx_data = rxb;
      tick();
      m_done = 1'b0;
      ak = ack;
      rx = rx_data;
      er = err;
   endtask

   logic [3:0] g, ak, cm;
   logic [7:0] tx, rx;
   logic       er;
   bit         ok;
   int         n;
   logic [3:0] rr_exp  [0:5];
   logic [7:0] rrtx_exp[0:5];

   initial begin
      rr_exp   = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
      rrtx_exp = '{8'hA0, 8'hB1, 8'hD3, 8'hA0, 8'hB1, 8'hD3};
      rst = 1'b0; req = '0; req_lock = '0; tx_data = '0; m_done = 1'b0; m_rx_data = '0;
      #2;
      reset_dut();
      check("rst_grant", grant, 4'b0000);
      check("rst_cs_n", cs_n, 4'hF);
      check("rst_ack", ack, 4'b0000);
      check("rst_err", err, 1'b0);
      check("rst_rx", rx_data, 8'h00);
      check("rst_m_start", m_start, 1'b0);
      check("rst_m_tx", m_tx_data, 8'h00);
      check("rst_m_abort", m_abort, 1'b0);

      // single request from requester 1
      tx_data = {8'h44, 8'h33, 8'hAA, 8'h11};
      req = 4'b0010;
      run_xfer(20, 8'h55, g, tx, cm, ak, rx, er);
      check("t1_grant", g, 4'b0010);
      check("t1_m_tx", tx, 8'hAA);
      check("t1_cs_mid", cm, 4'b1101);
      check("t1_ack", ak, 4'b0010);
      check("t1_rx", rx, 8'h55);
      check("t1_err", er, 1'b0);
      req = 4'b0000;
      tick();
      check("t1_cs_idle", cs_n, 4'hF);
      check("t1_grant_idle", grant, 4'b0000);

      // round robin over 1011 from a fresh reset
      reset_dut();
      tx_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      req = 4'b1011;
      for (int i = 0; i < 6; i++) begin
         run_xfer(3, 8'(8'h10 + i), g, tx, cm, ak, rx, er);
         check($sformatf("t2_grant%0d", i), g, rr_exp[i]);
         check($sformatf("t2_tx%0d", i), tx, rrtx_exp[i]);
         check($sformatf("t2_ack%0d", i), ak, rr_exp[i]);
         check($sformatf("t2_rx%0d", i), rx, 8'(8'h10 + i));
      end

      // serve requester 1 so that the pointer sits at 2, then a locked burst on 2
      req = 4'b0010;
      run_xfer(2, 8'h21, g, tx, cm, ak, rx, er);
      check("t3_pre_grant", g, 4'b0010);
      req = 4'b0101; req_lock = 4'b0100;
      tx_data[23:16] = 8'h01; tx_data[7:0] = 8'h0F;
      run_xfer(2, 8'hE1, g, tx, cm, ak, rx, er);
      check("t3_b1_grant", g, 4'b0100);
      check("t3_b1_tx", tx, 8'h01);
      check("t3_b1_ack", ak, 4'b0100);
      watch_cs2 = 1'b1;
      tx_data[23:16] = 8'h02;
      run_xfer(2, 8'hE2, g, tx, cm, ak, rx, er);
      check("t3_b2_grant", g, 4'b0100);
      check("t3_b2_tx", tx, 8'h02);
      check("t3_b2_ack", ak, 4'b0100);
      // pause inside the burst: lock held, req[2] low
      req = 4'b0001;
      repeat (3) tick();
      check("t3_hold_grant", grant, 4'b0100);
      check("t3_hold_start", m_start, 1'b0);
      req = 4'b0101; tx_data[23:16] = 8'h03;
      run_xfer(2, 8'hE3, g, tx, cm, ak, rx, er);
      check("t3_b3_grant", g, 4'b0100);
      check("t3_b3_tx", tx, 8'h03);
      check("t3_b3_rx", rx, 8'hE3);
      req_lock = 4'b0000; req = 4'b0001;
      watch_cs2 = 1'b0;
      check("t3_cs2_gap", cs2_gap, 0);
      run_xfer(2, 8'hE4, g, tx, cm, ak, rx, er);
      check("t3_r0_grant", g, 4'b0001);
      check("t3_r0_tx", tx, 8'h0F);
      check("t3_r0_ack", ak, 4'b0001);
      req = 4'b0000;

      // watchdog on requester 1, then requester 3 normally
      tx_data = {8'h88, 8'h00, 8'h77, 8'h00};
      req = 4'b1010;
      wait_start(ok);
      check("t4_grant", grant, 4'b0010);
      n = 0;
      while (!m_abort && n < 100) begin
         tick();
         n++;
      end
      check("t4_abort_cycle", n, 64);
      check("t4_ack_at_abort", ack, 4'b0000);
      tick();
      check("t4_abort_pulse", m_abort, 1'b0);
      check("t4_ack", ack, 4'b0010);
      check("t4_err", err, 1'b1);
      check("t4_rx", rx_data, 8'h00);
      req = 4'b1000;
      run_xfer(4, 8'h99, g, tx, cm, ak, rx, er);
      check("t4_next_grant", g, 4'b1000);
      check("t4_next_tx", tx, 8'h88);
      check("t4_next_ack", ak, 4'b1000);
      check("t4_next_err", er, 1'b0);
      check("t4_next_rx", rx, 8'h99);
      req = 4'b0000;

      // asynchronous reset in the middle of a transfer
      req = 4'b0001;
      run_xfer(2, 8'h31, g, tx, cm, ak, rx, er);
      check("t5_pre_grant", g, 4'b0001);
      req = 4'b0100; tx_data[23:16] = 8'h5C;
      wait_start(ok);
      check("t5_grant", grant, 4'b0100);
      req = 4'b0101;
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      check("t5_async_cs_n", cs_n, 4'hF);
      check("t5_async_grant", grant, 4'b0000);
      check("t5_async_m_tx", m_tx_data, 8'h00);
      check("t5_async_rx", rx_data, 8'h00);
      tick();
      check("t5_rst_ack", ack, 4'b0000);
      check("t5_rst_m_start", m_start, 1'b0);
      rst = 1'b0;
      run_xfer(2, 8'h3E, g, tx, cm, ak, rx, er);
      check("t5_after_grant", g, 4'b0001);
      check("t5_after_ack", ak, 4'b0001);
      check("t5_after_rx", rx, 8'h3E);
      req = 4'b0000;

      // m_done on the timeout cycle, req dropped during WAIT
      tx_data[15:8] = 8'h5A;
      req = 4'b0010;
      wait_start(ok);
      check("t6_m_tx", m_tx_data, 8'h5A);
      req = 4'b0000; tx_data[15:8] = 8'hFF;
      repeat (64) tick();
      check("t6_abort_edge", m_abort, 1'b1);
      check("t6_m_tx_held", m_tx_data, 8'h5A);
      m_done = 1'b1; m_rx_data = 8'hC3;
      #1;
      check("t6_abort_suppressed", m_abort, 1'b0);
      tick();
      m_done = 1'b0;
      check("t6_ack", ack, 4'b0010);
      check("t6_err", err, 1'b0);
      check("t6_rx", rx_data, 8'hC3);
      tick();
      check("t6_grant_idle", grant, 4'b0000);

      check("onehot_invariants", inv_viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
